// File: rtl/osc_enable_seq_pkg.sv
// Shared types and defaults for the oscillator enable sequencer.
package osc_enable_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWRUP   = 3'd1,
    ST_ENABLE  = 3'd2,
    ST_READY   = 3'd3,
    ST_DISABLE = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  localparam int unsigned PU_DELAY_DEF   = 32'd8;
  localparam int unsigned LOCK_EDGES_DEF = 32'd16;
  localparam int unsigned TIMEOUT_DEF    = 32'd64;
  localparam int unsigned QUIET_DEF      = 32'd32;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 32'd1) ? 32'd1 : $clog2(max_val + 32'd1);
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Brings the asynchronous oscillator clock into CLK and flags its rising edges.
module osc_edge_sync (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic EDGE
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Two metastability flops followed by a history flop for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= D;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign EDGE = s2_q & ~s3_q;

endmodule

// File: rtl/osc_enable_seq.sv
// Power-up / enable sequencer for an on-chip oscillator with lock and loss detection.
module osc_enable_seq
  import osc_enable_seq_pkg::*;
#(
  parameter int unsigned PU_DELAY   = PU_DELAY_DEF,
  parameter int unsigned LOCK_EDGES = LOCK_EDGES_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned QUIET      = QUIET_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ,
  output logic ACK,
  output logic BUSY,
  output logic FAULT,
  output logic OSC_PU,
  output logic OSC_ENA,
  input  logic OSC_CLK_IN
);

  localparam int unsigned WW = cnt_width(PU_DELAY);
  localparam int unsigned LW = cnt_width(LOCK_EDGES);
  localparam int unsigned GW = cnt_width(TIMEOUT);
  localparam int unsigned QW = cnt_width(QUIET);

  // Terminal values: a transition fires when the counter is one short and this cycle also counts.
  localparam logic [WW-1:0] WAIT_LAST  = WW'(PU_DELAY - 32'd1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_EDGES - 32'd1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(TIMEOUT - 32'd1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET - 32'd1);
  localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_EDGES);
  localparam logic [GW-1:0] GAP_MAX    = GW'(TIMEOUT);
  localparam logic [QW-1:0] QUIET_MAX  = QW'(QUIET);

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [QW-1:0]   quiet_q, quiet_d;
  logic            ack_q, busy_q, fault_q, pu_q, ena_q;
  logic            edge_s;

  osc_edge_sync u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .D    (OSC_CLK_IN),
    .EDGE (edge_s)
  );

  // Next-state and counter update; REQ low always wins over lock or timeout.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    lock_d  = lock_q;
    gap_d   = gap_q;
    quiet_d = quiet_q;
    case (state_q)
      ST_OFF: begin
        wait_d = '0;
        if (REQ) state_d = ST_PWRUP;
        else     state_d = ST_OFF;
      end
      ST_PWRUP: begin
        if (!REQ) begin
          state_d = ST_DISABLE;
          quiet_d = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_ENABLE;
          lock_d  = '0;
          gap_d   = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_ENABLE: begin
        if (!REQ) begin
          state_d = ST_DISABLE;
          quiet_d = '0;
        end else if (edge_s) begin
          // An edge always clears the gap, even in the cycle it would have timed out.
          gap_d  = '0;
          lock_d = (lock_q == LOCK_MAX) ? lock_q : lock_q + LW'(1);
          if (lock_q == LOCK_LAST) state_d = ST_READY;
          else                     state_d = ST_ENABLE;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_FAULT;
        end else begin
          gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + GW'(1);
        end
      end
      ST_READY: begin
        if (!REQ) begin
          state_d = ST_DISABLE;
          quiet_d = '0;
        end else if (edge_s) begin
          gap_d = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_FAULT;
        end else begin
          gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + GW'(1);
        end
      end
      ST_DISABLE: begin
        // REQ is deliberately ignored until the oscillator has gone quiet.
        if (edge_s) begin
          quiet_d = '0;
        end else if (quiet_q == QUIET_LAST) begin
          state_d = ST_OFF;
        end else begin
          quiet_d = (quiet_q == QUIET_MAX) ? quiet_q : quiet_q + QW'(1);
        end
      end
      ST_FAULT: begin
        if (!REQ) state_d = ST_OFF;
        else      state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state so they track the state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_OFF;
      wait_q  <= '0;
      lock_q  <= '0;
      gap_q   <= '0;
      quiet_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      pu_q    <= 1'b0;
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      lock_q  <= lock_d;
      gap_q   <= gap_d;
      quiet_q <= quiet_d;
      ack_q   <= (state_d == ST_READY);
      busy_q  <= (state_d == ST_PWRUP) || (state_d == ST_ENABLE) || (state_d == ST_DISABLE);
      fault_q <= (state_d == ST_FAULT);
      pu_q    <= (state_d == ST_PWRUP) || (state_d == ST_ENABLE) ||
                 (state_d == ST_READY) || (state_d == ST_DISABLE);
      ena_q   <= (state_d == ST_ENABLE) || (state_d == ST_READY);
    end
  end

  assign ACK     = ack_q;
  assign BUSY    = busy_q;
  assign FAULT   = fault_q;
  assign OSC_PU  = pu_q;
  assign OSC_ENA = ena_q;

endmodule

// File: tb/tb_osc_enable_seq.sv
// Directed bench for osc_enable_seq (PU_DELAY=4, LOCK_EDGES=8, TIMEOUT=32, QUIET=16).
module tb_osc_enable_seq;

  logic CLK = 1'b0;
  logic RST;
  logic REQ;
  logic ACK, BUSY, FAULT, OSC_PU, OSC_ENA;
  logic osc_in;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit osc_on = 1'b0;
  int ph    = 0;

  osc_enable_seq #(
    .PU_DELAY   (4),
    .LOCK_EDGES (8),
    .TIMEOUT    (32),
    .QUIET      (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ        (REQ),
    .ACK        (ACK),
    .BUSY       (BUSY),
    .FAULT      (FAULT),
    .OSC_PU     (OSC_PU),
    .OSC_ENA    (OSC_ENA),
    .OSC_CLK_IN (osc_in)
  );

  always #5 CLK = ~CLK;

  // One CLK cycle; cycle n is the interval just after the n-th rising edge.
  // The oscillator model has an 8-cycle period, high for the first 4 cycles.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (osc_on) begin
      osc_in = (ph < 4) ? 1'b1 : 1'b0;
      ph = (ph + 1) % 8;
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // REQ rises in cycle 0: PWRUP from cycle 1, ENABLE from cycle 5.
  task automatic start_req(input bit with_osc);
    cyc = 0;
    REQ = 1'b1;
    tick();
    check("pwrup_pu", OSC_PU, 1'b1);
    check("pwrup_ena", OSC_ENA, 1'b0);
    check("pwrup_busy", BUSY, 1'b1);
    run_to(4);
    check("pwrup_ena_c4", OSC_ENA, 1'b0);
    if (with_osc) begin
      osc_on = 1'b1;
      ph = 0;
    end
    tick();
    check("enable_ena_c5", OSC_ENA, 1'b1);
    check("enable_busy_c5", BUSY, 1'b1);
  endtask

  task automatic stop_osc();
    osc_on = 1'b0;
    osc_in = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    REQ = 1'b1;
    osc_in = 1'b0;
    repeat (3) tick();
    check("rst_ack", ACK, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_fault", FAULT, 1'b0);
    check("rst_pu", OSC_PU, 1'b0);
    check("rst_ena", OSC_ENA, 1'b0);
    RST = 1'b0;
    REQ = 1'b0;
    repeat (4) tick();
    check("off_pu", OSC_PU, 1'b0);

    // Enable and lock: rises at 5,13,..,61; 8th edge pulse in cycle 63, ACK in 64.
    start_req(1'b1);
    run_to(63);
    check("lock_ack_c63", ACK, 1'b0);
    tick();
    check("lock_ack_c64", ACK, 1'b1);
    check("lock_busy_c64", BUSY, 1'b0);
    check("lock_ena_c64", OSC_ENA, 1'b1);
    // Clock loss: last edge pulse in 63, so 32 edge-free cycles end at 95.
    run_to(66);
    stop_osc();
    run_to(95);
    check("loss_ack_c95", ACK, 1'b1);
    check("loss_fault_c95", FAULT, 1'b0);
    tick();
    check("loss_ack_c96", ACK, 1'b0);
    check("loss_fault_c96", FAULT, 1'b1);
    check("loss_pu_c96", OSC_PU, 1'b0);
    check("loss_ena_c96", OSC_ENA, 1'b0);
    REQ = 1'b0;
    tick();
    check("loss_clear_c97", FAULT, 1'b0);
    repeat (4) tick();

    // Lock timeout: no oscillator, ENABLE from cycle 5, FAULT at 37.
    start_req(1'b0);
    run_to(36);
    check("lto_fault_c36", FAULT, 1'b0);
    check("lto_ena_c36", OSC_ENA, 1'b1);
    tick();
    check("lto_fault_c37", FAULT, 1'b1);
    check("lto_pu_c37", OSC_PU, 1'b0);
    check("lto_ena_c37", OSC_ENA, 1'b0);
    check("lto_busy_c37", BUSY, 1'b0);
    tick();
    check("lto_sticky_c38", FAULT, 1'b1);
    REQ = 1'b0;
    tick();
    check("lto_clear_c39", FAULT, 1'b0);
    check("lto_off_pu_c39", OSC_PU, 1'b0);
    repeat (4) tick();

    // Boundary: edge pulse in cycle 36, exactly when the gap would time out.
    start_req(1'b0);
    run_to(34);
    osc_in = 1'b1;
    run_to(37);
    check("edge_wins_fault_c37", FAULT, 1'b0);
    check("edge_wins_ena_c37", OSC_ENA, 1'b1);
    REQ = 1'b0;
    tick();
    osc_in = 1'b0;
    check("edge_wins_dis_ena_c38", OSC_ENA, 1'b0);
    check("edge_wins_dis_pu_c38", OSC_PU, 1'b1);
    run_to(53);
    check("edge_wins_quiet_pu_c53", OSC_PU, 1'b1);
    tick();
    check("edge_wins_quiet_pu_c54", OSC_PU, 0);
    repeat (4) tick();

    // Disable from READY with edges continuing (pulses 71 and 79), REQ re-raised at 70.
    start_req(1'b1);
    run_to(64);
    check("dis_ack_c64", ACK, 1'b1);
    REQ = 1'b0;
    tick();
    check("dis_ack_c65", ACK, 1'b0);
    check("dis_ena_c65", OSC_ENA, 1'b0);
    check("dis_pu_c65", OSC_PU, 1'b1);
    check("dis_busy_c65", BUSY, 1'b1);
    run_to(70);
    REQ = 1'b1;
    run_to(72);
    check("dis_ignore_req_ena_c72", OSC_ENA, 1'b0);
    check("dis_ignore_req_busy_c72", BUSY, 1'b1);
    run_to(80);
    stop_osc();
    run_to(95);
    check("dis_quiet_pu_c95", OSC_PU, 1'b1);
    tick();
    check("dis_off_pu_c96", OSC_PU, 1'b0);
    check("dis_off_busy_c96", BUSY, 1'b0);
    tick();
    check("dis_repwrup_pu_c97", OSC_PU, 1'b1);
    check("dis_repwrup_busy_c97", BUSY, 1'b1);
    // Abort during PWRUP: DISABLE from 98, OFF at 114.
    REQ = 1'b0;
    run_to(101);
    check("abort_ena_c101", OSC_ENA, 1'b0);
    run_to(113);
    check("abort_pu_c113", OSC_PU, 1'b1);
    tick();
    check("abort_pu_c114", OSC_PU, 1'b0);
    check("abort_busy_c114", BUSY, 1'b0);
    repeat (4) tick();

    // Reset while READY.
    start_req(1'b1);
    run_to(64);
    check("rstr_ack_c64", ACK, 1'b1);
    RST = 1'b1;
    tick();
    check("rstr_ack", ACK, 1'b0);
    check("rstr_pu", OSC_PU, 1'b0);
    check("rstr_ena", OSC_ENA, 1'b0);
    check("rstr_busy", BUSY, 1'b0);
    check("rstr_fault", FAULT, 1'b0);
    RST = 1'b0;
    REQ = 1'b0;
    stop_osc();
    tick();
    check("rstr_off_pu", OSC_PU, 1'b0);
    repeat (4) tick();

    // REQ drops in the cycle of the 8th edge pulse: DISABLE wins, ACK never rises.
    start_req(1'b1);
    run_to(63);
    REQ = 1'b0;
    check("race_ack_c63", ACK, 1'b0);
    tick();
    check("race_ack_c64", ACK, 1'b0);
    check("race_ena_c64", OSC_ENA, 1'b0);
    check("race_pu_c64", OSC_PU, 1'b1);
    check("race_busy_c64", BUSY, 1'b1);
    tick();
    check("race_ack_c65", ACK, 1'b0);
    stop_osc();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
